// File: rtl/lap_stopwatch_if.sv
// Purpose : Handshake/control bundle between a lap_stopwatch and its controller.
//           The controller side (master) drives the start/stop/clear/lap
//           strobes and the lap_ready back-pressure. The stopwatch side
//           (slave) returns the count, status and lap FIFO head.
// Ports   : start, stop, clear, lap, lap_ready (master -> slave)
//           count, running, wrap, lap_valid, lap_data, lap_level,
//           lap_ovf (slave -> master)
//           down (master -> slave), present only when the build macro
//           LAP_STOPWATCH_COUNTDOWN_EN is defined
interface lap_stopwatch_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LAP_DEPTH  = 4
);
   localparam int LVL_W = $clog2(LAP_DEPTH + 1);

   logic                  start;
   logic                  stop;
   logic                  clear;
   logic                  lap;
   logic                  lap_ready;
`ifdef LAP_STOPWATCH_COUNTDOWN_EN
   logic                  down;
`endif
   logic [DATA_WIDTH-1:0] count;
   logic                  running;
   logic                  wrap;
   logic                  lap_valid;
   logic [DATA_WIDTH-1:0] lap_data;
   logic [LVL_W-1:0]      lap_level;
   logic                  lap_ovf;

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
   modport master (
      output start, stop, clear, lap, lap_ready, down,
      input  count, running, wrap, lap_valid, lap_data, lap_level, lap_ovf
   );
   modport slave (
      input  start, stop, clear, lap, lap_ready, down,
      output count, running, wrap, lap_valid, lap_data, lap_level, lap_ovf
   );
`else
   modport master (
      output start, stop, clear, lap, lap_ready,
      input  count, running, wrap, lap_valid, lap_data, lap_level, lap_ovf
   );
   modport slave (
      input  start, stop, clear, lap, lap_ready,
      output count, running, wrap, lap_valid, lap_data, lap_level, lap_ovf
   );
`endif
endinterface

// File: rtl/lap_stopwatch.sv
// Purpose : Stopwatch counter (0..MAX, wrapping) with a lap-capture FIFO.
//           Build macro LAP_STOPWATCH_COUNTDOWN_EN adds a down input that
//           reverses the count direction while running.
// Ports   : i_clk   - clock, all state changes on the rising edge
//           i_reset - synchronous active-high reset
//           bus     - lap_stopwatch_if.slave (controls in, count/status/FIFO out)
//
// state  | meaning
// S_IDLE | stopped, count held at 0
// S_RUN  | counting every edge
// S_HOLD | stopped, count retained
module lap_stopwatch #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX        = 99,
   parameter int LAP_DEPTH  = 4
) (
   input  logic           i_clk,
   input  logic           i_reset,
   lap_stopwatch_if.slave bus
);
   localparam int PTR_W = $clog2(LAP_DEPTH);
   localparam int LVL_W = $clog2(LAP_DEPTH + 1);
   localparam logic [DATA_WIDTH-1:0] MAX_C = DATA_WIDTH'(MAX);
   localparam logic [DATA_WIDTH-1:0] ONE_C = DATA_WIDTH'(1);
   localparam logic [LVL_W-1:0]      FULL_C = LVL_W'(LAP_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_count;
   logic                  r_running;
   logic                  r_wrap;

   logic [DATA_WIDTH-1:0] r_mem [LAP_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [LVL_W-1:0]      r_level;
   logic                  r_ovf;

   logic                  w_down;
   logic                  w_go;
   logic [DATA_WIDTH-1:0] w_step;
   logic                  w_step_wrap;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_push_ok;

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
   assign w_down = bus.down;
`else
   assign w_down = 1'b0;
`endif

   // stop outranks start, so a simultaneous start/stop never starts counting
   assign w_go = bus.start & ~bus.stop;

   always_comb begin
      w_step      = r_count + ONE_C;
      w_step_wrap = 1'b0;
      if (w_down) begin
         if (r_count == '0) begin
            w_step      = MAX_C;
            w_step_wrap = 1'b1;
         end else begin
            w_step = r_count - ONE_C;
         end
      end else if (r_count == MAX_C) begin
         w_step      = '0;
         w_step_wrap = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_running <= 1'b0;
         r_wrap    <= 1'b0;
      end else if (bus.clear) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_running <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
                  // counting down out of IDLE starts from the top, not a wrap
                  r_count   <= w_down ? MAX_C : w_step;
               end
            end
            S_RUN: begin
               if (bus.stop) begin
                  r_state   <= S_HOLD;
                  r_running <= 1'b0;
               end else begin
                  r_count <= w_step;
                  r_wrap  <= w_step_wrap;
               end
            end
            S_HOLD: begin
               if (w_go) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
                  r_count   <= w_step;
                  r_wrap    <= w_step_wrap;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_count   <= '0;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   // lap captures the pre-edge count; a lap alongside stop still lands
   assign w_full    = (r_level == FULL_C);
   assign w_pop     = (r_level != '0) & bus.lap_ready;
   assign w_push    = (r_state == S_RUN) & bus.lap & ~bus.clear;
   assign w_push_ok = w_push & (~w_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset || bus.clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
         if (w_push && !w_push_ok) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset && w_push_ok) r_mem[r_wr_ptr] <= r_count;
   end

   assign bus.count     = r_count;
   assign bus.running   = r_running;
   assign bus.wrap      = r_wrap;
   assign bus.lap_valid = (r_level != '0);
   assign bus.lap_data  = r_mem[r_rd_ptr];
   assign bus.lap_level = r_level;
   assign bus.lap_ovf   = r_ovf;
endmodule
